// File: rtl/audio_clock_manager_pkg.sv
// Shared constants and helpers for the audio clock manager and its dividers.
package audio_clock_manager_pkg;

    localparam int DEFAULT_MASTER_FREQ  = 100_000_000;
    localparam int DEFAULT_BIT_CLK_FREQ = 1_411_200;
    localparam int DEFAULT_TEMPO_FREQ   = 180;
    localparam int DEFAULT_DIV_BITS     = 20;

    localparam int FRAME_BITS     = 32;
    localparam int CHANNEL_BITS   = 16;
    localparam int FRAME_CNT_BITS = $clog2(FRAME_BITS);

    // WS is high from the last left bit up to, but not including, the last right bit
    localparam logic [FRAME_CNT_BITS-1:0] WS_FIRST = FRAME_CNT_BITS'(CHANNEL_BITS - 1);
    localparam logic [FRAME_CNT_BITS-1:0] WS_LAST  = FRAME_CNT_BITS'(FRAME_BITS - 2);

    // Half period of a derived clock in master cycles, truncated
    function automatic int halfPeriod(input int masterFreq, input int outFreq);
        return masterFreq / (2 * outFreq);
    endfunction

endpackage

// File: rtl/audio_clock_manager_frequency_generator.sv
// Square-wave divider: counts 0..HALF-1, toggles on the terminal count and
// exposes combinational strobes for the edge about to happen.
module frequency_generator
    import audio_clock_manager_pkg::*;
#(
    parameter int MASTER_FREQ = DEFAULT_MASTER_FREQ,
    parameter int FREQ        = DEFAULT_BIT_CLK_FREQ,
    parameter int BITS        = DEFAULT_DIV_BITS
) (
    input  logic CLK,
    input  logic Reset,
    output logic SquareWave,
    output logic RiseStrobe,
    output logic FallStrobe
);

    localparam int HALF = halfPeriod(MASTER_FREQ, FREQ);
    localparam logic [BITS-1:0] TERMINAL = BITS'(HALF - 1);

    generate
        if ((HALF < 1) || ((longint'(HALF) - 1) >= (longint'(1) << BITS))) begin : genRangeCheck
            $error("frequency_generator: half period does not fit in the divider width");
        end
    endgenerate

    logic [BITS-1:0] count;
    logic            terminal;

    assign terminal   = (count == TERMINAL);
    // Strobes are high in the cycle whose closing edge toggles SquareWave
    assign RiseStrobe = terminal & ~SquareWave;
    assign FallStrobe = terminal &  SquareWave;

    // Divider counter and output toggle
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count      <= '0;
            SquareWave <= 1'b0;
        end else if (terminal) begin
            count      <= '0;
            SquareWave <= ~SquareWave;
        end else begin
            count      <= count + BITS'(1);
        end
    end

endmodule

// File: rtl/audio_clock_manager.sv
// I2S transmitter plus tempo clock, all derived from the master clock.
// The serializer advances on SCK falling events so data and WS settle a
// half bit before the DAC samples them on the rising edge.
module audio_clock_manager
    import audio_clock_manager_pkg::*;
#(
    parameter int MASTER_FREQ  = DEFAULT_MASTER_FREQ,
    parameter int BIT_CLK_FREQ = DEFAULT_BIT_CLK_FREQ,
    parameter int TEMPO_FREQ   = DEFAULT_TEMPO_FREQ,
    parameter int DIV_BITS     = DEFAULT_DIV_BITS
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [FRAME_BITS-1:0] InputData,
    output logic                  I2S_CLK,
    output logic                  I2S_WS,
    output logic                  I2S_DATA,
    output logic                  SyncCLK,
    output logic                  Tempo_CLK
);

    logic sckRise, sckFall, tempoRise, tempoFall;
    // Only the SCK fall strobe is needed; the rest are collected here
    logic unusedStrobes;
    assign unusedStrobes = sckRise ^ tempoRise ^ tempoFall;

    frequency_generator #(
        .MASTER_FREQ (MASTER_FREQ),
        .FREQ        (BIT_CLK_FREQ),
        .BITS        (DIV_BITS)
    ) sckGen (
        .CLK        (CLK),
        .Reset      (Reset),
        .SquareWave (I2S_CLK),
        .RiseStrobe (sckRise),
        .FallStrobe (sckFall)
    );

    frequency_generator #(
        .MASTER_FREQ (MASTER_FREQ),
        .FREQ        (TEMPO_FREQ),
        .BITS        (DIV_BITS)
    ) tempoGen (
        .CLK        (CLK),
        .Reset      (Reset),
        .SquareWave (Tempo_CLK),
        .RiseStrobe (tempoRise),
        .FallStrobe (tempoFall)
    );

    logic [FRAME_CNT_BITS-1:0] bitCnt;
    logic [FRAME_CNT_BITS-1:0] nextBit;
    logic [FRAME_BITS-1:0]     shiftReg;

    assign nextBit = bitCnt + FRAME_CNT_BITS'(1);

    // Frame counter, sample latch, serial shifter and WS decode
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            bitCnt   <= FRAME_CNT_BITS'(FRAME_BITS - 1);
            shiftReg <= '0;
            I2S_WS   <= 1'b0;
            I2S_DATA <= 1'b0;
            SyncCLK  <= 1'b0;
        end else begin
            SyncCLK <= 1'b0;
            if (sckFall) begin
                bitCnt <= nextBit;
                I2S_WS <= (nextBit >= WS_FIRST) && (nextBit <= WS_LAST);
                if (nextBit == '0) begin
                    // Frame start: MSB goes straight out, the rest waits in the shifter
                    shiftReg <= InputData;
                    I2S_DATA <= InputData[FRAME_BITS-1];
                    SyncCLK  <= 1'b1;
                end else begin
                    I2S_DATA <= shiftReg[FRAME_BITS-2];
                    shiftReg <= {shiftReg[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_clock_manager.sv
// Bench for audio_clock_manager: timing checks after reset, a vector table of
// frames scored through a queue, and hand-written reset-in-frame sequence.
module tb_audio_clock_manager;
    import audio_clock_manager_pkg::*;

    localparam int H_EXP      = 35;
    localparam int SCK_PERIOD = 70;
    localparam int FRAME_CYC  = 2240;
    localparam int TEMPO_HALF = 50;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] InputData = '0;
    logic        I2S_CLK, I2S_WS, I2S_DATA, SyncCLK, Tempo_CLK;

    always #5 CLK = ~CLK;

    audio_clock_manager #(.TEMPO_FREQ(1_000_000)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .InputData (InputData),
        .I2S_CLK   (I2S_CLK),
        .I2S_WS    (I2S_WS),
        .I2S_DATA  (I2S_DATA),
        .SyncCLK   (SyncCLK),
        .Tempo_CLK (Tempo_CLK)
    );

    typedef struct {
        logic [31:0] data;
        logic [15:0] expLeft;
        logic [15:0] expRight;
        bit          midChange;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          monEn = 1'b0;
    logic [31:0] expQ[$];

    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // WS as seen at the rise following fall b, stored at bit 31-b
    function automatic logic [31:0] wsModel();
        logic [31:0] m;
        for (int b = 0; b < 32; b++) m[31-b] = (b >= 15 && b <= 30);
        return m;
    endfunction

    task automatic waitSync();
        for (int n = 0; n < 3000; n++) begin
            @(posedge CLK); #1;
            if (SyncCLK) return;
        end
        checks++; errors++;
        $display("FAIL sync timeout: got no SyncCLK within 3000 cycles, expected one");
    endtask

    task automatic waitFalls(input int n);
        logic prev;
        int   cnt;
        prev = I2S_CLK;
        cnt  = 0;
        for (int k = 0; k < n * 80 + 10; k++) begin
            @(posedge CLK); #1;
            if (prev && !I2S_CLK) cnt++;
            prev = I2S_CLK;
            if (cnt == n) return;
        end
        checks++; errors++;
        $display("FAIL fall timeout: got %0d SCK falls, expected %0d", cnt, n);
    endtask

    // Monitor: gathers bits at SCK rises into frames, pops the scoreboard, checks periods
    initial begin
        bit          prevSck, prevTempo, inFrame, haveRise, haveSync, haveTempo;
        int          bitIdx, lastRise, lastSync, lastTempo;
        logic [31:0] gotWord, gotWs, expWord;
        gotWord = '0; gotWs = '0; bitIdx = 0;
        lastRise = 0; lastSync = 0; lastTempo = 0;
        forever begin
            @(posedge CLK); #1;
            if (!monEn) begin
                inFrame = 0; haveRise = 0; haveSync = 0; haveTempo = 0;
                prevSck = 0; prevTempo = 0;
                continue;
            end
            if (SyncCLK) begin
                if (haveSync) check("sync period", cyc - lastSync, FRAME_CYC);
                haveSync = 1; lastSync = cyc;
                inFrame = 1; bitIdx = 0;
            end
            if (I2S_CLK && !prevSck) begin
                if (haveRise) check("sck period", cyc - lastRise, SCK_PERIOD);
                haveRise = 1; lastRise = cyc;
                if (inFrame) begin
                    gotWord[31-bitIdx] = I2S_DATA;
                    gotWs[31-bitIdx]   = I2S_WS;
                    bitIdx++;
                    if (bitIdx == 32) begin
                        inFrame = 0;
                        if (expQ.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL frame: got %h, expected no frame", gotWord);
                        end else begin
                            expWord = expQ.pop_front();
                            check("frame data", gotWord, expWord);
                            check("frame ws", gotWs, wsModel());
                        end
                    end
                end
            end
            if (Tempo_CLK != prevTempo) begin
                if (haveTempo) check("tempo half period", cyc - lastTempo, TEMPO_HALF);
                haveTempo = 1; lastTempo = cyc;
            end
            prevSck   = I2S_CLK;
            prevTempo = Tempo_CLK;
        end
    end

    initial begin
        vec_t vec[7];
        int   syncAt;
        vec[0] = '{32'hA5A5_0F0F, 16'hA5A5, 16'h0F0F, 1'b0};
        vec[1] = '{32'hFFFF_0000, 16'hFFFF, 16'h0000, 1'b1};
        vec[2] = '{32'h8000_0001, 16'h8000, 16'h0001, 1'b0};
        vec[3] = '{32'h0001_8000, 16'h0001, 16'h8000, 1'b0};
        vec[4] = '{32'h8000_0001, 16'h8000, 16'h0001, 1'b0};
        vec[5] = '{32'h0001_8000, 16'h0001, 16'h8000, 1'b0};
        vec[6] = '{32'h3C5A_96E1, 16'h3C5A, 16'h96E1, 1'b0};

        // Reset held for 5 cycles
        Reset = 1'b1;
        InputData = vec[0].data;
        repeat (5) @(posedge CLK);
        #1;
        check("reset outputs", {27'b0, I2S_CLK, I2S_WS, I2S_DATA, SyncCLK, Tempo_CLK}, 32'h0);
        expQ.push_back({vec[0].expLeft, vec[0].expRight});
        @(negedge CLK);
        Reset = 1'b0;
        monEn = 1'b1;

        // Edge c is the c-th posedge after release
        for (int c = 1; c <= 71; c++) begin
            @(posedge CLK); #1;
            if (c == H_EXP - 1)     check("sck low before H", I2S_CLK, 0);
            if (c == H_EXP)         check("sck rise at H", I2S_CLK, 1);
            if (c == 2 * H_EXP - 1) check("sck high before 2H", I2S_CLK, 1);
            if (c == 2 * H_EXP)     check("sck fall at 2H", I2S_CLK, 0);
            if (c == 2 * H_EXP - 1) check("sync before 2H", SyncCLK, 0);
            if (c == 2 * H_EXP)     check("sync at 2H", SyncCLK, 1);
            if (c == 2 * H_EXP + 1) check("sync after 2H", SyncCLK, 0);
            if (c == 2 * H_EXP)     check("first data bit", I2S_DATA, vec[0].expLeft[15]);
            if (c == 2 * H_EXP)     check("first ws", I2S_WS, 0);
            if (c == TEMPO_HALF - 1) check("tempo low before T", Tempo_CLK, 0);
            if (c == TEMPO_HALF)     check("tempo rise at T", Tempo_CLK, 1);
        end

        // Frames from the table; each value is driven once the previous one is latched
        for (int i = 1; i < 7; i++) begin
            if (vec[i].midChange) waitFalls(10);
            InputData = vec[i].data;
            expQ.push_back({vec[i].expLeft, vec[i].expRight});
            waitSync();
        end
        repeat (2220) @(posedge CLK);
        #1;
        monEn = 1'b0;
        check("queue drained", expQ.size(), 0);

        // Reset asserted at b = 20
        waitSync();
        waitFalls(20);
        check("ws at b20", I2S_WS, 1);
        Reset = 1'b1;
        #1;
        check("reset mid-frame outputs", {27'b0, I2S_CLK, I2S_WS, I2S_DATA, SyncCLK, Tempo_CLK}, 32'h0);
        repeat (3) @(posedge CLK);
        InputData = 32'h1234_5678;
        expQ.push_back(32'h1234_5678);
        @(negedge CLK);
        Reset = 1'b0;
        monEn = 1'b1;
        syncAt = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge CLK); #1;
            if (SyncCLK && syncAt == 0) syncAt = c;
        end
        check("first sync after reset", syncAt, 2 * H_EXP);
        repeat (2190) @(posedge CLK);
        #1;
        monEn = 1'b0;
        check("queue drained after reset", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
